// File: rtl/ptmch_trg_pkg.sv
// Shared definitions for the trigger-pulse logger: register map,
// control/status bit positions and the event record layout.
package ptmch_trg_pkg;

    localparam int NUM_CH = 5;

    // Register word addresses
    localparam logic [3:0] ADDR_FIFO_DATA = 4'd0;
    localparam logic [3:0] ADDR_STATUS    = 4'd1;
    localparam logic [3:0] ADDR_CNT0      = 4'd2;
    localparam logic [3:0] ADDR_CNT1      = 4'd3;
    localparam logic [3:0] ADDR_CNT2      = 4'd4;
    localparam logic [3:0] ADDR_CNT3      = 4'd5;
    localparam logic [3:0] ADDR_CNT4      = 4'd6;
    localparam logic [3:0] ADDR_CTRL      = 4'd7;
    localparam logic [3:0] ADDR_TS_NOW    = 4'd8;

    // CTRL bit positions
    localparam int CTRL_EN_BIT  = 0;
    localparam int CTRL_IRQ_BIT = 1;
    localparam int CTRL_CLR_BIT = 8;

    // STATUS bit positions; fill count lives in [8:0]
    localparam int STS_OVF_BIT   = 31;
    localparam int STS_EMPTY_BIT = 30;
    localparam int STS_FULL_BIT  = 29;

    // One queued event: which channels rose, and when
    typedef struct packed {
        logic [4:0]  ch;
        logic [26:0] ts;
    } trg_rec_t;

endpackage

// File: rtl/ptmch_trg_fifo.sv
// Synchronous FIFO with fall-through head data. A push into a full FIFO
// is accepted only when a pop happens in the same cycle; a pop on an
// empty FIFO is ignored. clr empties the FIFO and wins over push/pop.
module ptmch_trg_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    // Pointer and occupancy bookkeeping
    // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage array write port
    // NOTE: the storage array has no reset; count/empty guard every read of stale data.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/ptmch_trg_log.sv
// Trigger-pulse logger: detects rising edges on TRG_PLS, timestamps them,
// counts them per channel and queues one record per edge cycle for the
// Avalon-MM reader. TRG_IRQ flags a non-empty queue when enabled.
module ptmch_trg_log
    import ptmch_trg_pkg::*;
#(
    parameter int P_FIFO_DEPTH = 16,
    parameter int P_TS_WIDTH   = 32
) (
    input  logic        CLK160M,
    input  logic        RESET_N,
    input  logic [4:0]  TRG_PLS,
    input  logic [3:0]  AVS_ADDRESS,
    input  logic        AVS_READ,
    input  logic        AVS_WRITE,
    input  logic [31:0] AVS_WRITEDATA,
    output logic [31:0] AVS_READDATA,
    output logic        TRG_IRQ
);

    localparam int CW = $clog2(P_FIFO_DEPTH) + 1;

    logic                  rst_meta;
    logic                  rst_sync;
    logic [4:0]            trg_d;
    logic [4:0]            rise;
    logic [P_TS_WIDTH-1:0] ts_q;
    logic                  ctrl_en;
    logic                  ctrl_irq_en;
    logic                  ovf;
    logic                  irq_q;
    logic [31:0]           rdata_q;
    logic [31:0]           rd_mux;
    trg_rec_t              rec_q;
    logic                  rec_vld_q;
    logic                  wr_ctrl;
    logic                  clr;
    logic                  capture;
    logic                  fifo_pop;
    trg_rec_t              fifo_head;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CW-1:0]         fifo_count;
    logic [NUM_CH-1:0][15:0] cnt_all;
    logic                  unused_wdata;

    assign unused_wdata = ^{AVS_WRITEDATA[31:9], AVS_WRITEDATA[7:2]};

    assign rise     = TRG_PLS & ~trg_d;
    assign wr_ctrl  = AVS_WRITE && (AVS_ADDRESS == ADDR_CTRL);
    assign clr      = wr_ctrl && AVS_WRITEDATA[CTRL_CLR_BIT];
    assign capture  = ctrl_en && (rise != '0) && !clr;
    assign fifo_pop = AVS_READ && (AVS_ADDRESS == ADDR_FIFO_DATA);

    // Reset synchronizer: assertion is immediate, release follows CLK160M
    always_ff @(posedge CLK160M or negedge RESET_N) begin
        if (!RESET_N) begin
            rst_meta <= 1'b0;
            rst_sync <= 1'b0;
        end else begin
            rst_meta <= 1'b1;
            rst_sync <= rst_meta;
        end
    end

    // Edge-detect delay, free-running timestamp and one-deep capture stage
    always_ff @(posedge CLK160M or negedge rst_sync) begin
        if (!rst_sync) begin
            trg_d     <= '0;
            ts_q      <= '0;
            rec_q     <= '0;
            rec_vld_q <= 1'b0;
        end else begin
            trg_d     <= TRG_PLS;
            ts_q      <= ts_q + P_TS_WIDTH'(1);
            rec_vld_q <= capture;
            if (capture) rec_q <= '{ch: rise, ts: ts_q[26:0]};
        end
    end

    // Control register, sticky overflow and registered interrupt
    always_ff @(posedge CLK160M or negedge rst_sync) begin
        if (!rst_sync) begin
            ctrl_en     <= 1'b0;
            ctrl_irq_en <= 1'b0;
            ovf         <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                ctrl_en     <= AVS_WRITEDATA[CTRL_EN_BIT];
                ctrl_irq_en <= AVS_WRITEDATA[CTRL_IRQ_BIT];
            end
            if (clr) begin
                ovf <= 1'b0;
            end else if (rec_vld_q && fifo_full && !fifo_pop) begin
                ovf <= 1'b1;
            end
            irq_q <= ctrl_irq_en && !fifo_empty;
        end
    end

    // Per-channel saturating edge counters
    for (genvar n = 0; n < NUM_CH; n++) begin : g_cnt
        logic [15:0] cnt_q;

        // Count enabled rising edges on channel n, hold at all-ones
        always_ff @(posedge CLK160M or negedge rst_sync) begin
            if (!rst_sync) begin
                cnt_q <= '0;
            end else if (clr) begin
                cnt_q <= '0;
            end else if (ctrl_en && rise[n] && (cnt_q != 16'hFFFF)) begin
                cnt_q <= cnt_q + 16'd1;
            end
        end

        assign cnt_all[n] = cnt_q;
    end

    ptmch_trg_fifo #(
        .DEPTH (P_FIFO_DEPTH),
        .WIDTH ($bits(trg_rec_t))
    ) u_fifo (
        .clk   (CLK160M),
        .rst_n (rst_sync),
        .clr   (clr),
        .push  (rec_vld_q),
        .pop   (fifo_pop),
        .wdata (rec_q),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Register read multiplexer; unmapped addresses read as zero
    // NOTE: rd_mux gets a default first so no path through this block infers a latch.
    always_comb begin
        rd_mux = '0;
        case (AVS_ADDRESS)
            ADDR_FIFO_DATA: rd_mux = fifo_empty ? 32'h0 : fifo_head;
            ADDR_STATUS: begin
                rd_mux[STS_OVF_BIT]   = ovf;
                rd_mux[STS_EMPTY_BIT] = fifo_empty;
                rd_mux[STS_FULL_BIT]  = fifo_full;
                rd_mux[8:0]           = 9'(fifo_count);
            end
            ADDR_CNT0: rd_mux = {16'h0, cnt_all[0]};
            ADDR_CNT1: rd_mux = {16'h0, cnt_all[1]};
            ADDR_CNT2: rd_mux = {16'h0, cnt_all[2]};
            ADDR_CNT3: rd_mux = {16'h0, cnt_all[3]};
            ADDR_CNT4: rd_mux = {16'h0, cnt_all[4]};
            ADDR_CTRL: begin
                rd_mux[CTRL_EN_BIT]  = ctrl_en;
                rd_mux[CTRL_IRQ_BIT] = ctrl_irq_en;
            end
            ADDR_TS_NOW: rd_mux = 32'(ts_q);
            default: rd_mux = '0;
        endcase
    end

    // Read data register, updated only when a read is served
    always_ff @(posedge CLK160M or negedge rst_sync) begin
        if (!rst_sync) begin
            rdata_q <= '0;
        end else if (AVS_READ) begin
            rdata_q <= rd_mux;
        end
    end

    assign AVS_READDATA = rdata_q;
    assign TRG_IRQ      = irq_q;

endmodule

// File: tb/tb_ptmch_trg_log.sv
// Directed bench for ptmch_trg_log: reset state, single and coincident
// edges, FIFO overflow and full-with-pop, counter saturation, enable and
// interrupt gating, and asynchronous reset in the middle of a pulse.
module tb_ptmch_trg_log;
    import ptmch_trg_pkg::*;

    logic        CLK160M = 1'b0;
    logic        RESET_N;
    logic [4:0]  TRG_PLS;
    logic [3:0]  AVS_ADDRESS;
    logic        AVS_READ;
    logic        AVS_WRITE;
    logic [31:0] AVS_WRITEDATA;
    logic [31:0] AVS_READDATA;
    logic        TRG_IRQ;

    int          total = 0;
    int          bad   = 0;
    int unsigned pcount;

    ptmch_trg_log #(
        .P_FIFO_DEPTH (16),
        .P_TS_WIDTH   (32)
    ) dut (
        .CLK160M       (CLK160M),
        .RESET_N       (RESET_N),
        .TRG_PLS       (TRG_PLS),
        .AVS_ADDRESS   (AVS_ADDRESS),
        .AVS_READ      (AVS_READ),
        .AVS_WRITE     (AVS_WRITE),
        .AVS_WRITEDATA (AVS_WRITEDATA),
        .AVS_READDATA  (AVS_READDATA),
        .TRG_IRQ       (TRG_IRQ)
    );

    always #5 CLK160M = ~CLK160M;

    // Clock edges since reset release; the DUT timestamp seen in a cycle
    // is this count minus the two-stage reset-release delay.
    always @(posedge CLK160M or negedge RESET_N) begin
        if (!RESET_N) pcount <= 0;
        else          pcount <= pcount + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk_rec(input logic [4:0] ch, input int unsigned ts);
        logic [31:0] r;
        r = {ch, ts[26:0]};
        return r;
    endfunction

    task automatic avs_write(input logic [3:0] a, input logic [31:0] d);
        @(negedge CLK160M);
        AVS_ADDRESS   = a;
        AVS_WRITEDATA = d;
        AVS_WRITE     = 1'b1;
        @(negedge CLK160M);
        AVS_WRITE     = 1'b0;
    endtask

    task automatic avs_read(input logic [3:0] a, output logic [31:0] d);
        @(negedge CLK160M);
        AVS_ADDRESS = a;
        AVS_READ    = 1'b1;
        @(negedge CLK160M);
        AVS_READ    = 1'b0;
        d           = AVS_READDATA;
    endtask

    // High for w cycles starting at the next negedge; returns the timestamp
    // the DUT sees in the rising cycle.
    task automatic pulse(input logic [4:0] ch, input int w, output int unsigned ts_at);
        @(negedge CLK160M);
        TRG_PLS = ch;
        ts_at   = pcount - 2;
        repeat (w) @(negedge CLK160M);
        TRG_PLS = '0;
    endtask

    initial begin
        logic [31:0] rd;
        int unsigned ts_a;
        int unsigned ts_new;
        int unsigned fill_ts [17];

        RESET_N       = 1'b0;
        TRG_PLS       = '0;
        AVS_ADDRESS   = '0;
        AVS_READ      = 1'b0;
        AVS_WRITE     = 1'b0;
        AVS_WRITEDATA = '0;

        // Reset state
        repeat (3) @(negedge CLK160M);
        check("rst_readdata", AVS_READDATA, 32'h0);
        check("rst_irq", {31'h0, TRG_IRQ}, 32'h0);
        RESET_N = 1'b1;
        repeat (4) @(negedge CLK160M);
        avs_read(ADDR_STATUS, rd);  check("rst_status", rd, 32'h4000_0000);
        avs_read(ADDR_CTRL, rd);    check("rst_ctrl", rd, 32'h0);
        avs_read(ADDR_CNT0, rd);    check("rst_cnt0", rd, 32'h0);

        // Single 15-cycle pulse on channel 0 rising with ts = 100
        avs_write(ADDR_CTRL, 32'h1);
        while (pcount < 101) @(negedge CLK160M);
        pulse(5'b00001, 15, ts_a);
        repeat (2) @(negedge CLK160M);
        avs_read(ADDR_FIFO_DATA, rd); check("single_rec", rd, 32'h0800_0064);
        avs_read(ADDR_CNT0, rd);      check("single_cnt0", rd, 32'h1);
        avs_read(ADDR_STATUS, rd);    check("single_empty", rd, 32'h4000_0000);
        avs_read(4'hF, rd);           check("unmapped", rd, 32'h0);

        // Channels 1 and 3 rising together make one record
        pulse(5'b01010, 15, ts_a);
        repeat (2) @(negedge CLK160M);
        avs_read(ADDR_FIFO_DATA, rd); check("dual_rec", rd, mk_rec(5'b01010, ts_a));
        avs_read(ADDR_STATUS, rd);    check("dual_one_rec", rd, 32'h4000_0000);
        avs_read(ADDR_CNT1, rd);      check("dual_cnt1", rd, 32'h1);
        avs_read(ADDR_CNT3, rd);      check("dual_cnt3", rd, 32'h1);

        // 17 events into a 16-deep FIFO without reads
        for (int i = 0; i < 17; i++) pulse(5'b10000, 1, fill_ts[i]);
        repeat (2) @(negedge CLK160M);
        avs_read(ADDR_STATUS, rd);    check("ovf_status", rd, 32'hA000_0010);
        for (int i = 0; i < 16; i++) begin
            avs_read(ADDR_FIFO_DATA, rd);
            check($sformatf("ovf_rec%0d", i), rd, mk_rec(5'b10000, fill_ts[i]));
        end
        avs_read(ADDR_STATUS, rd);    check("ovf_drained", rd, 32'hC000_0000);
        avs_read(ADDR_FIFO_DATA, rd); check("pop_empty", rd, 32'h0);
        avs_read(ADDR_CNT4, rd);      check("ovf_cnt4", rd, 32'd17);

        // Clear, refill to full, then pop coincident with a new edge
        avs_write(ADDR_CTRL, 32'h101);
        avs_read(ADDR_STATUS, rd);    check("clr_status", rd, 32'h4000_0000);
        avs_read(ADDR_CNT4, rd);      check("clr_cnt4", rd, 32'h0);
        avs_read(ADDR_CTRL, rd);      check("clr_ctrl", rd, 32'h1);
        for (int i = 0; i < 16; i++) pulse(5'b00001, 1, fill_ts[i]);
        @(negedge CLK160M);
        AVS_ADDRESS = ADDR_FIFO_DATA;
        AVS_READ    = 1'b1;
        TRG_PLS     = 5'b00100;
        ts_new      = pcount - 2;
        @(negedge CLK160M);
        AVS_READ = 1'b0;
        check("fullpop_head", AVS_READDATA, mk_rec(5'b00001, fill_ts[0]));
        repeat (2) @(negedge CLK160M);
        TRG_PLS = '0;
        avs_read(ADDR_STATUS, rd);    check("fullpop_status", rd, 32'h2000_0010);
        for (int i = 0; i < 16; i++) begin
            avs_read(ADDR_FIFO_DATA, rd);
            if (i < 15) check($sformatf("fullpop_rec%0d", i), rd, mk_rec(5'b00001, fill_ts[i+1]));
            else        check("fullpop_last", rd, mk_rec(5'b00100, ts_new));
        end

        // Counter saturation on channel 2
        @(negedge CLK160M);
        force dut.g_cnt[2].cnt_q = 16'hFFFE;
        @(negedge CLK160M);
        release dut.g_cnt[2].cnt_q;
        for (int i = 0; i < 3; i++) pulse(5'b00100, 1, ts_a);
        repeat (2) @(negedge CLK160M);
        avs_read(ADDR_CNT2, rd);      check("sat_cnt2", rd, 32'h0000_FFFF);

        // Events with enable = 0 leave no trace
        avs_write(ADDR_CTRL, 32'h100);
        pulse(5'b00001, 3, ts_a);
        pulse(5'b00001, 3, ts_a);
        repeat (2) @(negedge CLK160M);
        avs_read(ADDR_STATUS, rd);    check("dis_status", rd, 32'h4000_0000);
        avs_read(ADDR_CNT0, rd);      check("dis_cnt0", rd, 32'h0);
        check("dis_irq", {31'h0, TRG_IRQ}, 32'h0);

        // Interrupt needs both irq_en and a non-empty FIFO
        avs_write(ADDR_CTRL, 32'h1);
        pulse(5'b00001, 2, ts_a);
        repeat (3) @(negedge CLK160M);
        check("irq_off_nonempty", {31'h0, TRG_IRQ}, 32'h0);
        avs_read(ADDR_STATUS, rd);    check("irq_status", rd, 32'h0000_0001);
        avs_write(ADDR_CTRL, 32'h3);
        check("irq_lag", {31'h0, TRG_IRQ}, 32'h0);
        @(negedge CLK160M);
        check("irq_on", {31'h0, TRG_IRQ}, 32'h1);
        avs_read(ADDR_FIFO_DATA, rd); check("irq_rec", rd, mk_rec(5'b00001, ts_a));
        @(negedge CLK160M);
        check("irq_drop", {31'h0, TRG_IRQ}, 32'h0);

        // Asynchronous reset in the middle of a pulse
        @(negedge CLK160M);
        TRG_PLS = 5'b00001;
        repeat (4) @(negedge CLK160M);
        avs_read(ADDR_CNT0, rd);      check("mid_cnt0", rd, 32'h2);
        check("mid_irq", {31'h0, TRG_IRQ}, 32'h1);
        #2 RESET_N = 1'b0;
        #1;
        check("arst_readdata", AVS_READDATA, 32'h0);
        check("arst_irq", {31'h0, TRG_IRQ}, 32'h0);
        @(negedge CLK160M);
        RESET_N = 1'b1;
        repeat (4) @(negedge CLK160M);
        TRG_PLS = '0;
        avs_read(ADDR_STATUS, rd);    check("arst_status", rd, 32'h4000_0000);
        avs_read(ADDR_CTRL, rd);      check("arst_ctrl", rd, 32'h0);
        avs_read(ADDR_CNT0, rd);      check("arst_cnt0", rd, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ptmch_trg_log.md
Name: ptmch_trg_log

Overview:
- Sits directly downstream of the SPI-instruction trigger matcher and consumes its 5-bit TRG_PLS bus.
- Each TRG_PLS bit is a high pulse about 15 CLK160M cycles wide.
- The block detects rising edges, timestamps them, counts them per channel, and queues event records in a FIFO.
- The Nios/Avalon side reads the FIFO and counters through a small register slave.

Parameters:
- P_FIFO_DEPTH, 16, number of event-record entries; power of 2, range 4..256.
- P_TS_WIDTH, 32, width of the free-running timestamp counter.

Ports:
- CLK160M  input  1  system clock. Sole clock of the block.
- RESET_N  input  1  asynchronous active-low reset.
- TRG_PLS  input  5  trigger pulses from the matcher, synchronous to CLK160M.
- AVS_ADDRESS  input  4  register word address.
- AVS_READ  input  1  read strobe, single-cycle.
- AVS_WRITE  input  1  write strobe, single-cycle.
- AVS_WRITEDATA  input  32  write data.
- AVS_READDATA  output  32  read data, valid 1 cycle after AVS_READ.
- TRG_IRQ  output  1  level interrupt: FIFO non-empty AND irq-enable.

Behaviour:
- Reset (async assert, sync deassert by the register clock):
  - FIFO empty; overflow flag 0; all counters 0; timestamp 0.
  - CTRL.enable = 0, CTRL.irq_en = 0; AVS_READDATA = 0; TRG_IRQ = 0.
- Edge detect:
  - trg_d is TRG_PLS registered once.
  - rise[4:0] = TRG_PLS & ~trg_d.
  - Only rising edges count; a level held high is one event.
- Timestamp: P_TS_WIDTH counter, +1 every cycle regardless of enable; wraps to 0 after all-ones.
- Event capture, only when CTRL.enable = 1 and rise != 0:
  - One record = {rise[4:0], ts[26:0]}, where ts is the timestamp value in the cycle rise is seen.
  - Simultaneous edges on several channels produce ONE record with several bits set.
  - The record is pushed on the cycle after rise (1-cycle latency).
- Per-channel counters CNT0..CNT4:
  - 16-bit, +1 on rise[n] when enabled.
  - Saturate at 16'hFFFF; no wrap.
- FIFO:
  - Push when full without a simultaneous pop: record dropped, OVF sticky set.
  - Push and pop in the same cycle while full: both take effect; no overflow.
  - Pop on empty: no state change, readdata = 0.
- Register map (read latency 1; reads of unmapped addresses return 0):
  - 0 FIFO_DATA (R): head record; the read pops it.
  - 1 STATUS (R): [31] OVF, [30] empty, [29] full, [8:0] fill count.
  - 2..6 CNT0..CNT4 (R): zero-extended counters.
  - 7 CTRL (R/W): [0] enable, [1] irq_en; write [8]=1 pulses a clear.
  - 8 TS_NOW (R): current timestamp.
- Clear (CTRL write with bit 8 = 1):
  - Same cycle: empties the FIFO, zeroes CNT0..4, clears OVF.
  - enable and irq_en take the written bits[1:0].
  - An event rising in that cycle is discarded.
- A read and a write strobe in the same cycle: write applied, read served; both are legal.
- TRG_IRQ is registered, so it reflects FIFO state with 1-cycle lag.

Decomposition:
- Package ptmch_trg_pkg holds:
  - Register address localparams.
  - Typedef trg_rec_t, a packed struct {logic [4:0] ch; logic [26:0] ts;}.
  - CTRL/STATUS bit-index constants.
- Sub-module ptmch_trg_fifo: synchronous FIFO parameterised by depth and width, with full, empty and count outputs, and fall-through head data.

Test Plan:
- Reset, then enable=1, single 15-cycle pulse on TRG_PLS[0] with ts=100 at the edge:
  - FIFO_DATA = {5'b00001, 27'd100}.
  - CNT0 = 1; STATUS.empty = 1 afterwards.
- Pulses on bits 1 and 3 rising in the same cycle: exactly one record with ch = 5'b01010; CNT1 = CNT3 = 1.
- 17 events with P_FIFO_DEPTH = 16 and no reads:
  - STATUS fill = 16, full = 1, OVF = 1.
  - The first 16 records are read in order; the 17th is lost.
- Full FIFO, then a FIFO_DATA read coincident with a new edge: fill stays 16, OVF stays 0, and the new record is last.
- Counter saturation: force CNT2 to 16'hFFFE, apply 3 edges → CNT2 = 16'hFFFF.
- Events with enable = 0:
  - No records and counters unchanged.
  - TRG_IRQ asserts only once irq_en = 1 and the FIFO is non-empty.
  - RESET_N asserted mid-pulse: all state returns to reset values immediately.
